// File: rtl/spi_master.sv
// SPI initiator: shifts 10-bit host commands out MSB first inside an SS_n frame.
// Read-data commands (type 2'b11) wait a turnaround, then capture one byte from MISO.
// Optional abort support is compiled in with `define SPI_MASTER_ABORT_EN.
//
// Ports:
//   clk, rst            - system/SPI clock, synchronous active-high reset
//   cmd_valid/cmd_ready - host command handshake
//   cmd_data[9:0]       - [9:8] type (00 wr addr, 01 wr data, 10 rd addr, 11 rd data),
//                         [7:0] payload
//   rsp_valid           - one-cycle pulse when rsp_data has a new byte
//   rsp_data[7:0]       - last byte read from MISO
//   busy                - high from frame start through the idle gap
//   SS_n, MOSI, MISO    - SPI bus
//   abort, abort_done   - (SPI_MASTER_ABORT_EN only) cut the frame short / ack pulse
module spi_master #(
    parameter int IDLE_GAP    = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
`ifdef SPI_MASTER_ABORT_EN
    ,
    input  logic       abort,
    output logic       abort_done
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        TURN,
        RECV,
        GAP
    } state_t;

    localparam int WMAX = (IDLE_GAP > TURN_CYCLES) ? IDLE_GAP : TURN_CYCLES;
    localparam int WW   = (WMAX < 2) ? 1 : $clog2(WMAX);

    localparam logic [WW-1:0] TURN_LAST = WW'(TURN_CYCLES - 1);
    localparam logic [WW-1:0] GAP_LAST  = WW'(IDLE_GAP - 1);

    state_t        state;
    state_t        state_n;
    logic [3:0]    bit_cnt;
    logic [3:0]    bit_cnt_n;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_cnt_n;
    logic [9:0]    tx;
    logic [9:0]    tx_n;
    logic          rd_frame;
    logic          rd_frame_n;
    logic [7:0]    rx;
    logic [7:0]    rx_n;
    logic          rsp_hit;
    logic          abort_hit;
    logic          mosi_n;
    logic          frame_n;

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        wait_cnt_n = wait_cnt;
        tx_n       = tx;
        rd_frame_n = rd_frame;
        rx_n       = rx;
        rsp_hit    = 1'b0;
        abort_hit  = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    tx_n       = cmd_data;
                    rd_frame_n = (cmd_data[9:8] == 2'b11);
                    bit_cnt_n  = 4'd0;
                    state_n    = START;
                end
            end
            START: begin
                // START repeats bit 9 (slave command-check cycle);
                // SHIFT then walks bit 9 down to bit 0.
                tx_n      = {tx[8:0], 1'b0};
                bit_cnt_n = 4'd0;
                state_n   = SHIFT;
            end
            SHIFT: begin
                tx_n = {tx[8:0], 1'b0};
                if (bit_cnt == 4'd9) begin
                    bit_cnt_n  = 4'd0;
                    wait_cnt_n = '0;
                    state_n    = rd_frame ? TURN : GAP;
                end else begin
                    bit_cnt_n = bit_cnt + 4'd1;
                end
            end
            TURN: begin
                if (wait_cnt == TURN_LAST) begin
                    wait_cnt_n = '0;
                    bit_cnt_n  = 4'd0;
                    state_n    = RECV;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            RECV: begin
                rx_n = {rx[6:0], MISO};
                if (bit_cnt == 4'd7) begin
                    bit_cnt_n  = 4'd0;
                    wait_cnt_n = '0;
                    rsp_hit    = 1'b1;
                    state_n    = GAP;
                end else begin
                    bit_cnt_n = bit_cnt + 4'd1;
                end
            end
            GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    wait_cnt_n = '0;
                    state_n    = IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

`ifdef SPI_MASTER_ABORT_EN
        if (abort && (state inside {START, SHIFT, TURN, RECV})) begin
            state_n    = GAP;
            wait_cnt_n = '0;
            bit_cnt_n  = 4'd0;
            rsp_hit    = 1'b0;
            abort_hit  = 1'b1;
        end
`endif

        // Outputs are registered, so they are derived from the next state.
        frame_n = (state_n inside {START, SHIFT, TURN, RECV});
        mosi_n  = 1'b0;
        if (state_n == START) begin
            mosi_n = tx_n[9];
        end else if (state_n == SHIFT) begin
            mosi_n = tx[9];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            wait_cnt  <= '0;
            tx        <= 10'd0;
            rd_frame  <= 1'b0;
            rx        <= 8'd0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            wait_cnt  <= wait_cnt_n;
            tx        <= tx_n;
            rd_frame  <= rd_frame_n;
            rx        <= rx_n;
            SS_n      <= ~frame_n;
            MOSI      <= mosi_n;
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            rsp_valid <= rsp_hit;
            if (rsp_hit) begin
                rsp_data <= rx_n;
            end
        end
    end

`ifdef SPI_MASTER_ABORT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_done <= 1'b0;
        end else begin
            abort_done <= abort_hit;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = abort_hit;
`endif

endmodule
